lstm_gate_mac: RTL and testbench
================================

Name: lstm_gate_mac

Overview:
- Upstream stage of the LSTM gate activation (sigmf / tanh units).
- Computes one gate pre-activation per vector: z = b + sum over k of (w_k * x_k), over N streamed element pairs.
- Arithmetic is signed Q8.24 fixed point, where 1.0 = 0x01000000.
- Delivers z through a valid/ready handshake, saturated to WIDTH bits, so the activation unit consumes it directly.

Parameters:
- WIDTH, 32: data width of weights, inputs, bias and result (signed Q8.24).
- FRAC, 24: number of fractional bits.
- N, 4: elements per dot product (N >= 1).
- ACC_WIDTH, 48: accumulator width. Must be >= 2*WIDTH-FRAC+clog2(N)+1 so the accumulator never overflows.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  element pair valid.
- in_ready  out  1  block can accept an element pair.
- in_w  in  WIDTH  weight w_k, signed Q8.24.
- in_x  in  WIDTH  input x_k, signed Q8.24.
- in_b  in  WIDTH  bias; sampled only on the first accepted element of a vector.
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accepts result.
- o_data  out  WIDTH  saturated pre-activation z, signed Q8.24.
- o_count  out  clog2(N+1)  number of elements accepted in the current vector (debug/visibility).

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=ACC, acc=0, cnt=0.
  - o_valid=0, o_data=0, o_count=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides every other event in the same cycle and aborts any partial vector.
- Accept: an element pair is accepted when in_valid && in_ready at a clk edge.
- in_ready = (state==ACC). It is combinational from state only, never from in_valid.
- Product: p = (signed in_w * signed in_x), full 2*WIDTH bits, then arithmetic shift right by FRAC.
  - Truncation is toward -inf (floor).
  - Result is sign-extended to ACC_WIDTH.
- State ACC, per accepted element:
  - If cnt==0: acc <= sext(in_b) + p.
  - Otherwise: acc <= acc + p.
  - cnt increments by 1.
  - If cnt==N-1: cnt <= 0 and state <= OUT. o_valid=1 and o_data are driven from the cycle after the N-th accept (latency 1).
  - in_valid low: no change.
- o_data saturation:
  - acc > 0x7FFFFFFF -> o_data = 0x7FFFFFFF.
  - acc < -2^31 -> o_data = 0x80000000.
  - Otherwise o_data = acc[WIDTH-1:0].
  - o_data is registered when entering OUT.
- State OUT:
  - in_ready=0; in_* are ignored.
  - o_valid=1, and o_data is held stable while o_ready=0.
  - On o_ready=1: o_valid <= 0, state <= ACC, acc <= 0.
  - o_data keeps its last value after handshake; it is don't-care when o_valid=0, but the bench expects the value held.
- Throughput: one element per cycle in ACC, plus one bubble cycle per vector for the OUT handshake. With o_ready tied high, a vector of N elements occupies N+1 cycles.
- o_count = cnt in ACC; N in OUT.
- Case N=1: every accept moves directly to OUT, and bias plus the single product form the result.
- The accumulator never wraps; intermediate sums are not saturated, only the final output is.

Test Plan:
- Basic: N=4, b=0, w_k=0x01000000, x_k=0x00800000 for all k, o_ready=1 -> o_valid high exactly 1 cycle, in the cycle after the 4th accept; o_data=0x02000000; in_ready low that cycle only.
- Sign and bias: N=4, b=0x00800000, pairs (0xFF000000,0x00400000) x4 -> o_data=0xFF800000 (-0.5).
- Saturation: w=x=0x7F000000 for all 4 elements, b=0 -> o_data=0x7FFFFFFF. Same with w=0x81000000 -> 0x80000000. Negative case: w=0x81000000 (-127.0), x=0x7F000000 (+127.0), b=0.
- Truncation: N=1, b=0, (w,x)=(0x00000001,0x00000001) -> o_data=0x00000000. Then (0xFFFFFFFF,0x00000001) -> 0xFFFFFFFF.
- Backpressure: hold o_ready=0 for 3 cycles after o_valid rises, while driving in_valid=1 with garbage -> o_data stable, in_ready=0, garbage not accumulated. The next vector result is correct.
- Reset mid-vector: accept 2 elements, pull rst low 1 cycle -> o_count=0, o_valid=0. A following full vector yields a result with no contribution from the aborted elements, and its bias is taken from its own first element.

Source files
------------

// File: rtl/lstm_gate_mac_if.sv
// Element-pair input and result output bundle for the LSTM gate MAC.
// slave is the MAC side, master is the producer/consumer side.
interface lstm_gate_mac_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_b;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic [CW-1:0]    o_count;

    modport slave (
        input  in_valid, in_w, in_x, in_b, o_ready,
        output in_ready, o_valid, o_data, o_count
    );

    modport master (
        output in_valid, in_w, in_x, in_b, o_ready,
        input  in_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/lstm_gate_mac.sv
// Q8.24 dot product plus bias feeding the LSTM gate activation units.
// Result is saturated to WIDTH bits and held until downstream accepts it.
module lstm_gate_mac #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 24,
    parameter int N         = 4,
    parameter int ACC_WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    lstm_gate_mac_if.slave   bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_ACC, S_OUT} state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          o_valid_q, o_valid_d;
    logic [WIDTH-1:0]              o_data_q, o_data_d;

    logic signed [2*WIDTH-1:0]     prod_full;
    logic signed [2*WIDTH-1:0]     prod_sh;
    logic signed [ACC_WIDTH-1:0]   p;
    logic signed [ACC_WIDTH-1:0]   b_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic [WIDTH-1:0]              sat;
    logic                          accept;
    logic                          last;

    // Arithmetic shift floors the full-precision product.
    always_comb begin
        prod_full = $signed(bus.in_w) * $signed(bus.in_x);
        prod_sh   = prod_full >>> FRAC;
        p         = ACC_WIDTH'(prod_sh);
        b_ext     = ACC_WIDTH'($signed(bus.in_b));
        sum       = ((cnt_q == '0) ? b_ext : acc_q) + p;
    end

    always_comb begin
        if (sum > MAX_V) begin
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sum < MIN_V) begin
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat = sum[WIDTH-1:0];
        end
    end

    assign accept = (state_q == S_ACC) && bus.in_valid;
    assign last   = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ACC:   if (accept && last) state_d = S_OUT;
            S_OUT:   if (bus.o_ready) state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        unique case (state_q)
            S_ACC: begin
                if (accept) begin
                    acc_d = sum;
                    if (last) begin
                        cnt_d     = '0;
                        o_valid_d = 1'b1;
                        o_data_d  = sat;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_OUT: begin
                if (bus.o_ready) begin
                    o_valid_d = 1'b0;
                    acc_d     = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    always_comb begin
        bus.in_ready = (state_q == S_ACC);
        bus.o_valid  = o_valid_q;
        bus.o_data   = o_data_q;
        bus.o_count  = (state_q == S_OUT) ? CW'(N) : cnt_q;
    end
endmodule

// File: tb/tb_lstm_gate_mac.sv
// Directed and random checks of lstm_gate_mac for N=4 and N=1 instances.
// Expected results are queued when a vector is driven, popped on output.
module tb_lstm_gate_mac;
    logic clk;
    logic rst;

    lstm_gate_mac_if #(.WIDTH(32), .CW(3)) bus4 ();
    lstm_gate_mac_if #(.WIDTH(32), .CW(1)) bus1 ();

    lstm_gate_mac #(
        .WIDTH(32), .FRAC(24), .N(4), .ACC_WIDTH(48)
    ) u4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    lstm_gate_mac #(
        .WIDTH(32), .FRAC(24), .N(1), .ACC_WIDTH(48)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp4_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] vw[4];
    logic [31:0] vx[4];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model4(input logic [31:0] b);
        longint acc;
        acc = longint'($signed(b));
        for (int k = 0; k < 4; k++) begin
            acc += (longint'($signed(vw[k])) *
                    longint'($signed(vx[k]))) >>> 24;
        end
        if (acc > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (acc < -64'sh80000000) return 32'h80000000;
        return acc[31:0];
    endfunction

    task automatic set_all(input logic [31:0] w, input logic [31:0] x);
        for (int k = 0; k < 4; k++) begin
            vw[k] = w;
            vx[k] = x;
        end
    endtask

    // Later beats carry a different bias that must be ignored.
    task automatic send_vec4(input logic [31:0] b, input logic [31:0] e);
        exp4_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            bus4.in_valid = 1'b1;
            bus4.in_w     = vw[k];
            bus4.in_x     = vx[k];
            bus4.in_b     = (k == 0) ? b : ~b;
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
    endtask

    task automatic check_out4(input string tag);
        int n;
        logic [31:0] e;
        n = 0;
        while (!bus4.o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus4.o_valid || exp4_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_result expected=result", tag);
        end else begin
            e = exp4_q.pop_front();
            chk(tag, 64'(bus4.o_data), 64'(e));
        end
        if (bus4.o_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send1(input string tag, input logic [31:0] w,
                         input logic [31:0] x, input logic [31:0] b,
                         input logic [31:0] e);
        logic [31:0] ex;
        exp1_q.push_back(e);
        bus1.in_valid = 1'b1;
        bus1.in_w     = w;
        bus1.in_x     = x;
        bus1.in_b     = b;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        chk({tag, "_valid"}, 64'(bus1.o_valid), 64'd1);
        chk({tag, "_inrdy"}, 64'(bus1.in_ready), 64'd0);
        ex = exp1_q.pop_front();
        chk(tag, 64'(bus1.o_data), 64'(ex));
        @(posedge clk); #1;
        chk({tag, "_done"}, 64'(bus1.o_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] rb;
        rst           = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.in_w     = '0;
        bus4.in_x     = '0;
        bus4.in_b     = '0;
        bus4.o_ready  = 1'b1;
        bus1.in_valid = 1'b0;
        bus1.in_w     = '0;
        bus1.in_x     = '0;
        bus1.in_b     = '0;
        bus1.o_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 64'(bus4.o_valid), 64'd0);
        chk("rst_o_data", 64'(bus4.o_data), 64'd0);
        chk("rst_o_count", 64'(bus4.o_count), 64'd0);
        chk("rst_in_ready", 64'(bus4.in_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        set_all(32'h01000000, 32'h00800000);
        send_vec4(32'h00000000, 32'h02000000);
        chk("basic_valid", 64'(bus4.o_valid), 64'd1);
        chk("basic_inrdy", 64'(bus4.in_ready), 64'd0);
        chk("basic_count", 64'(bus4.o_count), 64'd4);
        check_out4("basic_data");
        chk("basic_valid_drop", 64'(bus4.o_valid), 64'd0);
        chk("basic_inrdy_back", 64'(bus4.in_ready), 64'd1);
        chk("basic_held", 64'(bus4.o_data), 64'h02000000);
        chk("basic_count0", 64'(bus4.o_count), 64'd0);

        set_all(32'hFF000000, 32'h00400000);
        send_vec4(32'h00800000, 32'hFF800000);
        check_out4("sign_bias");

        set_all(32'h7F000000, 32'h7F000000);
        send_vec4(32'h00000000, 32'h7FFFFFFF);
        check_out4("sat_pos");
        set_all(32'h81000000, 32'h7F000000);
        send_vec4(32'h00000000, 32'h80000000);
        check_out4("sat_neg");

        send1("trunc_pos", 32'h00000001, 32'h00000001,
              32'h00000000, 32'h00000000);
        send1("trunc_neg", 32'hFFFFFFFF, 32'h00000001,
              32'h00000000, 32'hFFFFFFFF);
        send1("n1_bias", 32'h02000000, 32'h00800000,
              32'h01000000, 32'h02000000);

        bus4.o_ready = 1'b0;
        set_all(32'h01000000, 32'h00800000);
        send_vec4(32'h01000000, 32'h03000000);
        for (int c = 0; c < 3; c++) begin
            bus4.in_valid = 1'b1;
            bus4.in_w     = 32'h10000000;
            bus4.in_x     = 32'h10000000;
            bus4.in_b     = 32'h10000000;
            chk("bp_valid", 64'(bus4.o_valid), 64'd1);
            chk("bp_inrdy", 64'(bus4.in_ready), 64'd0);
            chk("bp_stable", 64'(bus4.o_data), 64'h03000000);
            chk("bp_count", 64'(bus4.o_count), 64'd4);
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
        bus4.o_ready  = 1'b1;
        check_out4("bp_data");
        set_all(32'hFF000000, 32'h00400000);
        send_vec4(32'h00800000, 32'hFF800000);
        check_out4("bp_next");

        for (int k = 0; k < 2; k++) begin
            bus4.in_valid = 1'b1;
            bus4.in_w     = 32'h01000000;
            bus4.in_x     = 32'h01000000;
            bus4.in_b     = 32'h05000000;
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
        chk("mid_count2", 64'(bus4.o_count), 64'd2);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rstmid_count", 64'(bus4.o_count), 64'd0);
        chk("rstmid_valid", 64'(bus4.o_valid), 64'd0);
        set_all(32'h01000000, 32'h00400000);
        send_vec4(32'h00800000, 32'h01800000);
        check_out4("rstmid_vec");

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                vw[k] = $urandom;
                vx[k] = $urandom;
            end
            rb = $urandom;
            e  = model4(rb);
            send_vec4(rb, e);
            check_out4("rand_vec");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
